// File: rtl/sram_arb_pkg.sv
// Shared defaults and FSM state type for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 128;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way grant logic. SRAM_ARB_RR_EN selects round-robin (with pointer);
// otherwise requester 0 has fixed priority and no pointer exists.
module sram_arb_rr (
`ifdef SRAM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

`ifdef SRAM_ARB_RR_EN
  // r_ptr = 1 means requester 1 wins the next conflict
  logic r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (o_gnt0 | o_gnt1) begin
      r_ptr <= o_gnt0;
    end
  end

  assign o_gnt0 = i_en & i_req0 & (~i_req1 | ~r_ptr);
  assign o_gnt1 = i_en & i_req1 & (~i_req0 |  r_ptr);
`else
  assign o_gnt0 = i_en & i_req0;
  assign o_gnt1 = i_en & i_req1 & ~i_req0;
`endif

endmodule

// File: rtl/sram_port_arb.sv
// Two-requester arbiter in front of a single-port synchronous SRAM macro;
// zero-fills the macro after reset. Optional macro: SRAM_ARB_RR_EN.
module sram_port_arb
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_i,
  output logic              mem_csb,
  output logic              mem_web,
  output logic              mem_oeb,
  input  logic [DATA_W-1:0] mem_o
);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                w_run;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_acc;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [ADDR_W-1:0]   r_mem_a;
  logic [DATA_W-1:0]   r_mem_i;
  logic                r_mem_csb;
  logic                r_mem_web;
  logic                r_p1_vld;
  logic                r_p1_id;
  logic                r_p2_vld;
  logic                r_p2_id;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = CLEAR;
    endcase
  end

  assign w_run   = (r_state == RUN);
  assign busy    = ~w_run;
  assign mem_oeb = ~w_run;

  sram_arb_rr u_arb (
`ifdef SRAM_ARB_RR_EN
    .clk    (clk),
    .rst    (rst),
`endif
    .i_en   (w_run),
    .i_req0 (r0_valid),
    .i_req1 (r1_valid),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  assign r0_ready    = w_gnt0;
  assign r1_ready    = w_gnt1;
  assign w_acc       = w_gnt0 | w_gnt1;
  assign w_sel_we    = w_gnt1 ? r1_we    : r0_we;
  assign w_sel_addr  = w_gnt1 ? r1_addr  : r0_addr;
  assign w_sel_wdata = w_gnt1 ? r1_wdata : r0_wdata;

  // Clear writes are issued one cycle behind the counter through the same
  // macro registers used for requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt <= '0;
      r_mem_a   <= '0;
      r_mem_i   <= '0;
      r_mem_csb <= 1'b1;
      r_mem_web <= 1'b1;
    end else if (!w_run) begin
      r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
      r_mem_a   <= r_clr_cnt;
      r_mem_i   <= '0;
      r_mem_csb <= 1'b0;
      r_mem_web <= 1'b0;
    end else if (w_acc) begin
      r_mem_a   <= w_sel_addr;
      r_mem_i   <= w_sel_wdata;
      r_mem_csb <= 1'b0;
      r_mem_web <= ~w_sel_we;
    end else begin
      r_mem_csb <= 1'b1;
      r_mem_web <= 1'b1;
    end
  end

  assign mem_a   = r_mem_a;
  assign mem_i   = r_mem_i;
  assign mem_csb = r_mem_csb;
  assign mem_web = r_mem_web;

  // Read tag pipeline: macro inputs, macro output, response register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_vld    <= 1'b0;
      r_p1_id     <= 1'b0;
      r_p2_vld    <= 1'b0;
      r_p2_id     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_p1_vld    <= w_acc & ~w_sel_we;
      r_p1_id     <= w_gnt1;
      r_p2_vld    <= r_p1_vld;
      r_p2_id     <= r_p1_id;
      r_rsp_valid <= r_p2_vld;
      if (r_p2_vld) begin
        r_rsp_id   <= r_p2_id;
        r_rsp_data <= mem_o;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_sram_port_arb.sv
// Randomized scoreboard bench for sram_port_arb with a behavioural SRAM macro
// and a reference memory/arbitration model.
module tb_sram_port_arb;

  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          r0_valid = 1'b0, r0_we = 1'b0, r1_valid = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_ready, r1_ready;
  logic          rsp_valid, rsp_id, busy;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_i;
  logic          mem_csb, mem_web, mem_oeb;
  logic [DW-1:0] mem_o = '0;

  sram_port_arb dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
    .mem_a(mem_a), .mem_i(mem_i), .mem_csb(mem_csb), .mem_web(mem_web), .mem_oeb(mem_oeb),
    .mem_o(mem_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mem_arr [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            since = 0;
  logic          acc0 = 1'b0, acc1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Behavioural synchronous SRAM macro, power-up contents random.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_arr[i] = DW'($urandom);
    forever begin
      @(posedge clk);
      if (!mem_csb) begin
        if (!mem_web) mem_arr[mem_a] = mem_i;
        else          mem_o <= mem_arr[mem_a];
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) since = 0;
    else     since++;
  end

  // Request side: arbitration model, pin checks, scoreboard push.
  initial begin
    logic          run_m, g0, g1, p_acc, p_we, id, we;
    logic [AW-1:0] p_addr, a;
    logic [DW-1:0] p_data, d;
`ifdef SRAM_ARB_RR_EN
    logic          fav;
    fav = 1'b0;
`endif
    p_acc = 1'b0; p_we = 1'b0; p_addr = '0; p_data = '0;
    forever begin
      @(negedge clk);
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (rst) begin
        chk("rst_ready0", 32'(r0_ready), 0);
        chk("rst_ready1", 32'(r1_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_mem_csb", 32'(mem_csb), 1);
        chk("rst_mem_web", 32'(mem_web), 1);
        chk("rst_mem_oeb", 32'(mem_oeb), 1);
        chk("rst_mem_a", 32'(mem_a), 0);
        chk("rst_mem_i", 32'(mem_i), 0);
        chk("rst_busy", 32'(busy), 1);
        q.delete();
        p_acc = 1'b0;
`ifdef SRAM_ARB_RR_EN
        fav = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end else begin
        run_m = (since >= DEPTH);
        chk("busy", 32'(busy), 32'(!run_m));
        chk("mem_oeb", 32'(mem_oeb), 32'(!run_m));
        if (since >= 1 && since <= DEPTH) begin
          chk("clr_csb", 32'(mem_csb), 0);
          chk("clr_web", 32'(mem_web), 0);
          chk("clr_addr", 32'(mem_a), 32'(since - 1));
          chk("clr_data", 32'(mem_i), 0);
        end else if (since > DEPTH) begin
          chk("pin_csb", 32'(mem_csb), 32'(!p_acc));
          chk("pin_web", 32'(mem_web), p_acc ? 32'(!p_we) : 32'd1);
          if (p_acc) chk("pin_addr", 32'(mem_a), 32'(p_addr));
          if (p_acc && p_we) chk("pin_wdata", 32'(mem_i), 32'(p_data));
        end
        g0 = 1'b0;
        g1 = 1'b0;
        if (run_m) begin
          if (r0_valid && r1_valid) begin
`ifdef SRAM_ARB_RR_EN
            g0 = !fav;
            g1 = fav;
`else
            g0 = 1'b1;
`endif
          end else begin
            g0 = r0_valid;
            g1 = r1_valid;
          end
        end
        chk("ready0", 32'(r0_ready), 32'(g0));
        chk("ready1", 32'(r1_ready), 32'(g1));
        p_acc = g0 | g1;
        if (p_acc) begin
          id = g1;
          we = g1 ? r1_we    : r0_we;
          a  = g1 ? r1_addr  : r0_addr;
          d  = g1 ? r1_wdata : r0_wdata;
          if (we) ref_mem[a] = d;
          else    q.push_back('{id, ref_mem[a], cyc + 3});
`ifdef SRAM_ARB_RR_EN
          fav = !id;
`endif
          p_we = we; p_addr = a; p_data = d;
        end
        acc0 = r0_valid && r0_ready;
        acc1 = r1_valid && r1_ready;
      end
    end
  end

  // Response monitor: pop and compare whenever the DUT presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rsp_valid) begin
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_unexpected: got id %0d data 0x%0h, required no response (cycle %0d)", rsp_id, rsp_data, cyc);
          end else begin
            e = q.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
          end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          vectors++;
          miscompares++;
          $display("FAIL rsp_missing: got no response, required id %0d data 0x%0h (cycle %0d)", e.id, e.data, cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int n, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t;
    if (n == 0) begin
      r0_valid = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
    end else begin
      r1_valid = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
    end
    t = 0;
    do begin
      step();
      t++;
    end while (!(n == 0 ? acc0 : acc1) && t < 300);
    vectors++;
    if (t >= 300) begin
      miscompares++;
      $display("FAIL accept_timeout: requester %0d got no ready, required acceptance", n);
    end
  endtask

  initial begin
    int g1cnt;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (DEPTH + 2) step();

    // Cleared memory reads back zero
    issue(0, 1'b0, 7'h05, '0);
    r0_valid = 1'b0;

    // Write then read of the same address on consecutive acceptances
    issue(0, 1'b1, 7'h10, 16'h1234);
    r0_valid = 1'b0;
    issue(1, 1'b0, 7'h10, '0);
    r1_valid = 1'b0;
    step();

    // Back-to-back reads at the address extremes
    issue(1, 1'b1, 7'h7F, 16'hBEEF);
    r1_valid = 1'b0;
    issue(0, 1'b0, 7'h7F, '0);
    issue(0, 1'b0, 7'h00, '0);
    r0_valid = 1'b0;
    repeat (4) step();

    // Continuous contention
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = AW'($urandom);
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = AW'($urandom);
    g1cnt = 0;
    repeat (20) begin
      step();
      if (acc1) g1cnt++;
      if (acc0) r0_addr = AW'($urandom);
      if (acc1) r1_addr = AW'($urandom);
    end
`ifdef SRAM_ARB_RR_EN
    chk("r1_grant_count", 32'(g1cnt), 10);
`else
    chk("r1_grant_count", 32'(g1cnt), 0);
`endif
    r0_valid = 1'b0;
    step();
    r1_valid = 1'b0;
    repeat (4) step();

    // Randomized traffic on a small address window to provoke hazards
    repeat (400) begin
      step();
      if (acc0 || !r0_valid) begin
        r0_valid = ($urandom_range(0, 3) != 0);
        r0_we    = 1'($urandom_range(0, 1));
        r0_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
        r0_wdata = DW'($urandom);
      end
      if (acc1 || !r1_valid) begin
        r1_valid = ($urandom_range(0, 2) != 0);
        r1_we    = 1'($urandom_range(0, 1));
        r1_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
        r1_wdata = DW'($urandom);
      end
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    repeat (6) step();

    // Reset while a read is in flight: response dropped, clear restarts
    issue(0, 1'b0, 7'h20, '0);
    r0_valid = 1'b0;
    step();
    #2 rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (DEPTH + 2) step();
    issue(1, 1'b0, 7'h10, '0);
    r1_valid = 1'b0;
    repeat (6) step();
    chk("queue_drained", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 Parameter ADDR_W, 7, macro address width.
REQ-002 Parameter DATA_W, 16, macro word width.
REQ-003 Parameter DEPTH, 128, words in the macro; DEPTH SHALL equal 2**ADDR_W.
REQ-004 clk  in  1  single clock; the macro CE pin is tied to clk externally.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rN_valid  in  1  request from requester N, N in {0,1}.
REQ-007 rN_ready  out  1  request N accepted this cycle.
REQ-008 rN_we  in  1  1 = write, 0 = read.
REQ-009 rN_addr  in  ADDR_W  word address.
REQ-010 rN_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  read data valid.
REQ-012 rsp_id  out  1  requester index owning rsp_data.
REQ-013 rsp_data  out  DATA_W  read data.
REQ-014 busy  out  1  clear sequence in progress.
REQ-015 mem_a / mem_i  out  ADDR_W / DATA_W  macro address and write data.
REQ-016 mem_csb / mem_web / mem_oeb  out  1 each  macro chip select, write enable and output enable, all active-low.
REQ-017 mem_o  in  DATA_W  macro read data.

Function
REQ-018 FSM states: CLEAR and RUN; reset enters CLEAR.
REQ-019 CLEAR: one write per cycle, mem_a = 0..DEPTH-1, mem_i = 0, mem_csb = 0, mem_web = 0; both rN_ready = 0; busy = 1; after address DEPTH-1 the FSM goes to RUN, so CLEAR lasts exactly DEPTH cycles.
REQ-020 RUN: at most one request is granted per cycle; rN_ready SHALL be combinational and equal to (RUN and rN_valid and granted N).
REQ-021 A request is accepted on the clock edge where valid and ready are both high; a requester SHALL hold valid, we, addr and wdata stable until accepted.
REQ-022 An accepted request drives registered macro inputs in the next cycle (csb = 0, web = ~we, a, i); with no acceptance, mem_csb = 1 and mem_web = 1.
REQ-023 Read latency: acceptance at edge N means rsp_valid = 1 with rsp_data = mem_o and rsp_id = requester for exactly one cycle after edge N+2; responses return in acceptance order.
REQ-024 mem_oeb = 0 whenever the FSM is in RUN; mem_oeb = 1 in CLEAR.
REQ-025 Write at edge N followed by a read of the same address accepted at edge N+1 SHALL return the new data.
REQ-026 Only one valid request: it is granted regardless of arbitration state.
REQ-027 Writes produce no response.

Reset
REQ-028 During and after rst: rN_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, mem_csb = 1, mem_web = 1, mem_oeb = 1, mem_a = 0, mem_i = 0, busy = 1, clear counter = 0, round-robin pointer = 0.
REQ-029 rst asserted mid-operation drops all in-flight responses and restarts CLEAR from address 0.

Configuration
REQ-030 SRAM_ARB_RR_EN defined: round-robin arbitration. After a grant to N, the pointer favours 1-N on the next conflict.
REQ-031 SRAM_ARB_RR_EN undefined: fixed priority, requester 0 always wins; the pointer logic is absent.

Structure
REQ-032 Package sram_arb_pkg SHALL hold the ADDR_W, DATA_W and DEPTH defaults and the state enum (CLEAR, RUN).
REQ-033 Sub-module sram_arb_rr, the 2-way grant logic including the pointer, SHALL be separated out.

Verification
REQ-034 Reset released -> busy high for 128 cycles, mem_web low with mem_a 0..127 and mem_i 0, then busy low; a read of address 0x05 returns 0x0000.
REQ-035 r0 writes 0x1234 to address 0x10, then r1 reads 0x10 on the next cycle -> rsp_valid 2 cycles after the read acceptance, rsp_id = 1, rsp_data = 0x1234.
REQ-036 Both requesters read continuously with SRAM_ARB_RR_EN defined -> grants alternate 0,1,0,1; without the macro -> r0 granted every cycle and r1_ready stays 0.
REQ-037 Back-to-back reads of 0x7F then 0x00 -> two consecutive rsp_valid cycles in order, carrying the correct data.
REQ-038 rst pulsed during a pending read at address 0x20 -> no rsp_valid, busy rises, CLEAR restarts at address 0.
